// File: rtl/uart_boot_loader_if.sv
// Control half of the UART register bus: chip select, direction, address.
// Data travels on the top-level tristate bus so only the owner drives it.
interface uart_boot_loader_if #(
    parameter int ADDR_BUS_WIDTH = 11
);
    logic                      cs;
    logic                      w_r;
    logic [ADDR_BUS_WIDTH-1:0] addr;

    modport master (output cs, w_r, addr);
    modport slave  (input  cs, w_r, addr);
endinterface

// File: rtl/uart_boot_loader.sv
// Boot loader: pulls a word-count-prefixed image from the UART register map
// into instruction memory, then echoes an XOR checksum byte back over TX.
module uart_boot_loader #(
    parameter int NB_BITS        = 8,
    parameter int DATA_BUS_WIDTH = 16,
    parameter int ADDR_BUS_WIDTH = 11,
    parameter int UART_BASE      = 0,
    parameter int IMEM_AW        = 11
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_start,
    uart_boot_loader_if.master        m_bus,
    inout  wire  [DATA_BUS_WIDTH-1:0] io_data_bus,
    output logic                      o_imem_we,
    output logic [IMEM_AW-1:0]        o_imem_addr,
    output logic [DATA_BUS_WIDTH-1:0] o_imem_data,
    output logic                      o_load_done
);
    localparam int CW = 2 * NB_BITS;
    localparam int AW = ADDR_BUS_WIDTH;
    localparam int DW = DATA_BUS_WIDTH;

    localparam logic [AW-1:0] A_TX     = AW'(UART_BASE + 0);
    localparam logic [AW-1:0] A_TXDONE = AW'(UART_BASE + 1);
    localparam logic [AW-1:0] A_TXRDY  = AW'(UART_BASE + 2);
    localparam logic [AW-1:0] A_RX     = AW'(UART_BASE + 3);
    localparam logic [AW-1:0] A_RXDONE = AW'(UART_BASE + 4);

    typedef enum logic [3:0] {
        S_IDLE,
        S_HDR_LO,
        S_HDR_HI,
        S_W_LO,
        S_W_HI,
        S_STORE,
        S_ACK_CLR,
        S_ACK_TX,
        S_ACK_RDY,
        S_ACK_POLL,
        S_ACK_UNRDY,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        PH_POLL,
        PH_READ,
        PH_CLR
    } phase_t;

    state_t               state_q, state_d;
    phase_t               ph_q, ph_d;
    logic                 cs_q, cs_d;
    logic                 wr_q, wr_d;
    logic [AW-1:0]        addr_q, addr_d;
    logic [DW-1:0]        dout_q, dout_d;
    logic [NB_BITS-1:0]   byte_q, byte_d;
    logic [NB_BITS-1:0]   lo_q, lo_d;
    logic [NB_BITS-1:0]   cntlo_q, cntlo_d;
    logic [NB_BITS-1:0]   csum_q, csum_d;
    logic [CW-1:0]        rem_q, rem_d;
    logic [IMEM_AW-1:0]   idx_q, idx_d;
    logic                 we_q, we_d;
    logic [IMEM_AW-1:0]   iaddr_q, iaddr_d;
    logic [DW-1:0]        idata_q, idata_d;
    logic                 done_q, done_d;

    logic [DW-1:0]        rd_w;
    logic                 unused_hi;
    logic                 fetch;
    logic                 ack_go;

    assign rd_w      = io_data_bus;
    assign unused_hi = ^rd_w[DW-1:NB_BITS];

    assign io_data_bus = (cs_q && wr_q) ? dout_q : {DW{1'bz}};

    assign m_bus.cs    = cs_q;
    assign m_bus.w_r   = wr_q;
    assign m_bus.addr  = addr_q;
    assign o_imem_we   = we_q;
    assign o_imem_addr = iaddr_q;
    assign o_imem_data = idata_q;
    assign o_load_done = done_q;

    // Next state, next bus access and datapath updates; one access per cycle.
    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        cs_d    = 1'b0;
        wr_d    = 1'b0;
        addr_d  = '0;
        dout_d  = '0;
        byte_d  = byte_q;
        lo_d    = lo_q;
        cntlo_d = cntlo_q;
        csum_d  = csum_q;
        rem_d   = rem_q;
        idx_d   = idx_q;
        we_d    = 1'b0;
        iaddr_d = iaddr_q;
        idata_d = idata_q;
        done_d  = done_q;
        fetch   = 1'b0;
        ack_go  = 1'b0;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (i_start) begin
                    state_d = S_HDR_LO;
                    ph_d    = PH_POLL;
                    csum_d  = '0;
                    idx_d   = '0;
                    done_d  = 1'b0;
                    fetch   = 1'b1;
                end
            end
            S_HDR_LO, S_HDR_HI, S_W_LO, S_W_HI: begin
                unique case (ph_q)
                    PH_POLL: begin
                        if (rd_w[0]) begin
                            ph_d   = PH_READ;
                            cs_d   = 1'b1;
                            addr_d = A_RX;
                        end else begin
                            fetch = 1'b1;
                        end
                    end
                    PH_READ: begin
                        byte_d = rd_w[NB_BITS-1:0];
                        ph_d   = PH_CLR;
                        cs_d   = 1'b1;
                        wr_d   = 1'b1;
                        addr_d = A_RXDONE;
                    end
                    default: begin
                        ph_d = PH_POLL;
                        unique case (state_q)
                            S_HDR_LO: begin
                                cntlo_d = byte_q;
                                state_d = S_HDR_HI;
                                fetch   = 1'b1;
                            end
                            S_HDR_HI: begin
                                if ({byte_q, cntlo_q} == '0) begin
                                    ack_go = 1'b1;
                                end else begin
                                    rem_d   = {byte_q, cntlo_q};
                                    state_d = S_W_LO;
                                    fetch   = 1'b1;
                                end
                            end
                            S_W_LO: begin
                                lo_d    = byte_q;
                                csum_d  = csum_q ^ byte_q;
                                state_d = S_W_HI;
                                fetch   = 1'b1;
                            end
                            default: begin
                                csum_d  = csum_q ^ byte_q;
                                state_d = S_STORE;
                                we_d    = 1'b1;
                                iaddr_d = idx_q;
                                idata_d = DW'({byte_q, lo_q});
                            end
                        endcase
                    end
                endcase
            end
            S_STORE: begin
                idx_d = idx_q + 1'b1;
                rem_d = rem_q - 1'b1;
                ph_d  = PH_POLL;
                if (rem_q == CW'(1)) begin
                    ack_go = 1'b1;
                end else begin
                    state_d = S_W_LO;
                    fetch   = 1'b1;
                end
            end
            S_ACK_CLR: begin
                state_d = S_ACK_TX;
                cs_d    = 1'b1;
                wr_d    = 1'b1;
                addr_d  = A_TX;
                dout_d  = DW'(csum_q);
            end
            S_ACK_TX: begin
                state_d = S_ACK_RDY;
                cs_d    = 1'b1;
                wr_d    = 1'b1;
                addr_d  = A_TXRDY;
                dout_d  = DW'(1);
            end
            S_ACK_RDY: begin
                state_d = S_ACK_POLL;
                cs_d    = 1'b1;
                addr_d  = A_TXDONE;
            end
            S_ACK_POLL: begin
                cs_d = 1'b1;
                if (rd_w[0]) begin
                    state_d = S_ACK_UNRDY;
                    wr_d    = 1'b1;
                    addr_d  = A_TXRDY;
                end else begin
                    addr_d = A_TXDONE;
                end
            end
            default: begin
                state_d = S_DONE;
                done_d  = 1'b1;
            end
        endcase

        if (fetch) begin
            cs_d   = 1'b1;
            wr_d   = 1'b0;
            addr_d = A_RXDONE;
        end
        if (ack_go) begin
            state_d = S_ACK_CLR;
            cs_d    = 1'b1;
            wr_d    = 1'b1;
            addr_d  = A_TXDONE;
            dout_d  = '0;
        end
    end

    // State and registered bus/imem outputs; reset abandons any load in flight.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            ph_q    <= PH_POLL;
            cs_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            dout_q  <= '0;
            byte_q  <= '0;
            lo_q    <= '0;
            cntlo_q <= '0;
            csum_q  <= '0;
            rem_q   <= '0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            iaddr_q <= '0;
            idata_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            cs_q    <= cs_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
            byte_q  <= byte_d;
            lo_q    <= lo_d;
            cntlo_q <= cntlo_d;
            csum_q  <= csum_d;
            rem_q   <= rem_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            iaddr_q <= iaddr_d;
            idata_q <= idata_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: tb/tb_uart_boot_loader.sv
// Bench for uart_boot_loader: UART register-map model, imem model,
// reference image/checksum model and a queue-based scoreboard.
module tb_uart_boot_loader;
    localparam int AW    = 11;
    localparam int DW    = 16;
    localparam int IAW   = 2;
    localparam int DEPTH = 4;

    localparam logic [AW-1:0] A_TX     = 11'd0;
    localparam logic [AW-1:0] A_TXDONE = 11'd1;
    localparam logic [AW-1:0] A_TXRDY  = 11'd2;
    localparam logic [AW-1:0] A_RX     = 11'd3;
    localparam logic [AW-1:0] A_RXDONE = 11'd4;

    typedef struct {
        logic [7:0] b;
        int         gap;
    } rx_t;

    typedef struct {
        logic [IAW-1:0] a;
        logic [DW-1:0]  d;
    } we_t;

    logic           clk   = 1'b0;
    logic           rst   = 1'b1;
    logic           start = 1'b0;
    wire  [DW-1:0]  bus;
    logic           imem_we;
    logic [IAW-1:0] imem_addr;
    logic [DW-1:0]  imem_data;
    logic           load_done;

    uart_boot_loader_if #(.ADDR_BUS_WIDTH(AW)) bif ();

    uart_boot_loader #(
        .NB_BITS       (8),
        .DATA_BUS_WIDTH(DW),
        .ADDR_BUS_WIDTH(AW),
        .UART_BASE     (0),
        .IMEM_AW       (IAW)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (start),
        .m_bus      (bif),
        .io_data_bus(bus),
        .o_imem_we  (imem_we),
        .o_imem_addr(imem_addr),
        .o_imem_data(imem_data),
        .o_load_done(load_done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    rx_t         rx_q[$];
    we_t         exp_we[$];
    logic [7:0]  exp_tx[$];
    logic [15:0] img[$];
    logic [15:0] imem_m [DEPTH];
    logic [15:0] ref_mem[DEPTH];

    logic [7:0]  tx_reg;
    logic        tx_done, tx_rdy, rx_done;
    logic [7:0]  rx_data;
    logic [15:0] rd_q;
    int          tx_timer;
    int          clr_cnt  = 0;
    int          spur_cnt = 0;
    int          rx_polls = 0;
    int          we_cnt   = 0;
    rx_t         rx_tmp;
    we_t         ew;

    assign bus = (bif.cs && !bif.w_r) ? rd_q : 16'hzzzz;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    // UART register block: acts on the bus at negedge, delivers queued RX bytes.
    always @(negedge clk) begin
        if (rst) begin
            tx_reg   <= '0;
            tx_done  <= 1'b0;
            tx_rdy   <= 1'b0;
            rx_done  <= 1'b0;
            rx_data  <= '0;
            rd_q     <= '0;
            tx_timer <= 0;
        end else begin
            if (bif.cs && bif.w_r) begin
                case (bif.addr)
                    A_TX:     tx_reg  <= bus[7:0];
                    A_TXDONE: tx_done <= bus[0];
                    A_TXRDY: begin
                        tx_rdy <= bus[0];
                        if (bus[0]) tx_timer <= $urandom_range(12, 2);
                    end
                    A_RXDONE: begin
                        if (!bus[0]) begin
                            if (rx_done) clr_cnt++;
                            else spur_cnt++;
                            rx_done <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end else if (bif.cs) begin
                case (bif.addr)
                    A_TX:     rd_q <= {8'h00, tx_reg};
                    A_TXDONE: rd_q <= {15'($urandom), tx_done};
                    A_TXRDY:  rd_q <= {15'h0, tx_rdy};
                    A_RX:     rd_q <= {8'($urandom), rx_data};
                    A_RXDONE: begin
                        rd_q <= {15'($urandom), rx_done};
                        rx_polls++;
                    end
                    default:  rd_q <= 16'h0;
                endcase
            end
            if (tx_rdy && !tx_done && tx_timer > 0) begin
                tx_timer <= tx_timer - 1;
                if (tx_timer == 1) tx_done <= 1'b1;
            end
            if (!rx_done && rx_q.size() > 0) begin
                if (rx_q[0].gap > 0) begin
                    rx_q[0].gap = rx_q[0].gap - 1;
                end else begin
                    rx_tmp = rx_q.pop_front();
                    rx_data <= rx_tmp.b;
                    rx_done <= 1'b1;
                end
            end
        end
    end

    // Scoreboard monitor: imem writes and the checksum byte handed to TX.
    always @(negedge clk) begin
        if (!rst) begin
            if (imem_we) begin
                we_cnt++;
                if (exp_we.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_we addr=%0h data=%0h",
                             imem_addr, imem_data);
                end else begin
                    ew = exp_we.pop_front();
                    chk("we_addr", 32'(imem_addr), 32'(ew.a));
                    chk("we_data", 32'(imem_data), 32'(ew.d));
                end
                imem_m[imem_addr] = imem_data;
            end
            if (bif.cs && bif.w_r && bif.addr == A_TXRDY && bus[0]) begin
                if (exp_tx.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_tx byte=%0h", tx_reg);
                end else begin
                    chk("tx_csum", 32'(tx_reg), 32'(exp_tx.pop_front()));
                end
            end
        end
    end

    // Reference: serialise img as the byte stream and predict writes + checksum.
    task automatic queue_image(input int gmin, input int gmax);
        logic [7:0]  x;
        logic [15:0] n;
        we_t         e;
        x = 8'h00;
        n = 16'(img.size());
        rx_q.push_back('{n[7:0], $urandom_range(gmax, gmin)});
        rx_q.push_back('{n[15:8], $urandom_range(gmax, gmin)});
        for (int i = 0; i < img.size(); i++) begin
            rx_q.push_back('{img[i][7:0], $urandom_range(gmax, gmin)});
            rx_q.push_back('{img[i][15:8], $urandom_range(gmax, gmin)});
            x = x ^ img[i][7:0] ^ img[i][15:8];
            e.a = IAW'(i % DEPTH);
            e.d = img[i];
            exp_we.push_back(e);
        end
        exp_tx.push_back(x);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic flush();
        rx_q.delete();
        exp_we.delete();
        exp_tx.delete();
    endtask

    task automatic run_load(input int gmin, input int gmax, input bit mid);
        int n, limit, we0, clr0, nb;
        nb    = 2 + 2 * img.size();
        we0   = we_cnt;
        clr0  = clr_cnt;
        limit = 200 + nb * (gmax + 12);
        queue_image(gmin, gmax);
        pulse_start();
        chk("done_cleared", 32'(load_done), 0);
        chk("cs_after_start", 32'(bif.cs), 1);
        if (mid) begin
            repeat (1500) @(negedge clk);
            pulse_start();
        end
        n = 0;
        while (!load_done && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk("load_done", 32'(load_done), 1);
        chk("cs_released", 32'(bif.cs), 0);
        chk("we_count", 32'(we_cnt - we0), 32'(img.size()));
        chk("rx_clears", 32'(clr_cnt - clr0), 32'(nb));
        chk("exp_we_left", 32'(exp_we.size()), 0);
        chk("exp_tx_left", 32'(exp_tx.size()), 0);
        if (!load_done) flush();
        for (int i = 0; i < img.size(); i++) ref_mem[i % DEPTH] = img[i];
        for (int a = 0; a < DEPTH; a++)
            chk("imem_word", 32'(imem_m[a]), 32'(ref_mem[a]));
    endtask

    task automatic rand_img(input int n);
        img.delete();
        for (int i = 0; i < n; i++) img.push_back(16'($urandom));
    endtask

    initial begin
        int n, p0, w0;
        for (int a = 0; a < DEPTH; a++) begin
            imem_m[a]  = '0;
            ref_mem[a] = '0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("rst_cs", 32'(bif.cs), 0);
            chk("rst_w_r", 32'(bif.w_r), 0);
            chk("rst_addr", 32'(bif.addr), 0);
            chk("rst_we", 32'(imem_we), 0);
            chk("rst_iaddr", 32'(imem_addr), 0);
            chk("rst_idata", 32'(imem_data), 0);
            chk("rst_done", 32'(load_done), 0);
        end

        img = '{16'h1234, 16'h5678};
        run_load(0, 0, 1'b0);

        img.delete();
        run_load(0, 3, 1'b0);

        img = '{16'h1234, 16'h5678};
        p0 = rx_polls;
        run_load(1000, 1000, 1'b1);
        chk("poll_continuous", 32'((rx_polls - p0) >= 5940), 1);

        for (int t = 0; t < 5; t++) begin
            rand_img($urandom_range(6, 1));
            run_load(0, 4, 1'b0);
        end

        img = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005};
        run_load(0, 2, 1'b0);
        chk("wrap_word0", 32'(imem_m[0]), 32'h0005);
        chk("wrap_word1", 32'(imem_m[1]), 32'h0002);

        rand_img(3);
        queue_image(0, 2);
        pulse_start();
        n = 0;
        while (!imem_we && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("first_we_seen", 32'(imem_we), 1);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("midrst_cs", 32'(bif.cs), 0);
        chk("midrst_we", 32'(imem_we), 0);
        chk("midrst_done", 32'(load_done), 0);
        flush();
        @(negedge clk);
        rst = 1'b0;
        w0 = we_cnt;
        repeat (30) @(negedge clk);
        chk("no_we_after_rst", 32'(we_cnt), 32'(w0));
        chk("partial_word0", 32'(imem_m[0]), 32'(img[0]));
        ref_mem[0] = img[0];

        rand_img(2);
        run_load(0, 3, 1'b0);

        chk("no_spurious_clr", 32'(spur_cnt), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
